imem_boot_loader: RTL and testbench

- Boot-time program loader upstream of the Y86 pipeline's fetch stage.
- Accepts a framed byte stream over a valid/ready handshake and writes the payload bytes into instruction memory through a byte-wide write port.
- Verifies an XOR checksum over the payload.
- Holds the pipeline in reset (`cpu_rst_n_o` low) until a frame loads cleanly.

---
 rtl/imem_boot_loader.sv | 137 +++++++++++++
 tb/tb_imem_boot_loader.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// Boot-time program loader: receives a length-prefixed, XOR-checksummed byte frame
// and copies the payload into instruction memory. The pipeline stays in reset until a frame loads cleanly.
module imem_boot_loader #(
   parameter int ADDR_W    = 10,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              in_valid_i,
   input  logic [7:0]        in_data_i,
   output logic              in_ready_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [7:0]        mem_wdata_o,
   output logic              cpu_rst_n_o,
   output logic              done_o,
   output logic              err_o,
   output logic [15:0]       byte_cnt_o
);

   typedef enum logic [2:0] {
      IDLE,
      LEN_LO,
      LEN_HI,
      DATA,
      CSUM,
      DONE,
      ERR
   } state_t;

   // Largest payload that fits between BASE_ADDR and the top of memory; 17 bits so 2^16 fits.
   localparam logic [16:0]       LEN_LIMIT = 17'((1 << ADDR_W) - BASE_ADDR);
   localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

   state_t            state_q;
   state_t            state_d;
   logic [15:0]       len_q;
   logic [7:0]        csum_q;
   logic              xfer;
   logic [15:0]       full_len;
   logic              last_byte;
   logic              ready_d;
   logic              done_d;
   logic              err_d;
   logic              we_d;
   logic [ADDR_W-1:0] addr_d;

   // A start pulse wins over a byte offered in the same cycle.
   assign xfer      = in_valid_i && in_ready_o && !start_i;
   assign full_len  = {in_data_i, len_q[7:0]};
   assign last_byte = (byte_cnt_o + 16'd1) == len_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         in_ready_o  <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         cpu_rst_n_o <= 1'b0;
         done_o      <= 1'b0;
         err_o       <= 1'b0;
      end else begin
         state_q     <= state_d;
         in_ready_o  <= ready_d;
         mem_we_o    <= we_d;
         cpu_rst_n_o <= done_d;
         done_o      <= done_d;
         err_o       <= err_d;
         if (we_d) begin
            mem_addr_o  <= addr_d;
            mem_wdata_o <= in_data_i;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      if (start_i) begin
         state_d = LEN_LO;
      end else if (xfer) begin
         case (state_q)
            LEN_LO: state_d = LEN_HI;
            LEN_HI: begin
               if ({1'b0, full_len} > LEN_LIMIT) begin
                  state_d = ERR;
               end else if (full_len == 16'd0) begin
                  state_d = CSUM;
               end else begin
                  state_d = DATA;
               end
            end
            DATA: begin
               if (last_byte) begin
                  state_d = CSUM;
               end
            end
            CSUM: state_d = (in_data_i == csum_q) ? DONE : ERR;
            default: state_d = state_q;
         endcase
      end
   end

   // Outputs are registered from the next state, so ready stays low for the cycle after a start.
   always_comb begin
      ready_d = (state_d inside {LEN_LO, LEN_HI, DATA, CSUM}) && !start_i;
      done_d  = (state_d == DONE);
      err_d   = (state_d == ERR);
      we_d    = xfer && (state_q == DATA);
      addr_d  = BASE + byte_cnt_o[ADDR_W-1:0];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         len_q      <= '0;
         csum_q     <= '0;
         byte_cnt_o <= '0;
      end else if (start_i) begin
         len_q      <= '0;
         csum_q     <= '0;
         byte_cnt_o <= '0;
      end else if (xfer) begin
         case (state_q)
            LEN_LO: len_q[7:0]  <= in_data_i;
            LEN_HI: len_q[15:8] <= in_data_i;
            DATA: begin
               csum_q     <= csum_q ^ in_data_i;
               byte_cnt_o <= byte_cnt_o + 16'd1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: two instances (base 0 and base 0x3FE) share one stream and
// are compared every cycle against a frame-level model, plus hand-computed literal checks.
module tb_imem_boot_loader;

   logic       clk = 1'b0;
   logic       rst_i = 1'b1;
   logic       start_i = 1'b0;
   logic       in_valid_i = 1'b0;
   logic [7:0] in_data_i = 8'h00;

   logic [1:0] rdy;
   logic [1:0] we;
   logic [1:0] rstn;
   logic [1:0] done;
   logic [1:0] err;
   logic [9:0]  addr  [2];
   logic [7:0]  wdata [2];
   logic [15:0] cnt   [2];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   imem_boot_loader #(.ADDR_W(10), .BASE_ADDR(0)) dut0 (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .in_valid_i(in_valid_i),
      .in_data_i(in_data_i), .in_ready_o(rdy[0]), .mem_we_o(we[0]),
      .mem_addr_o(addr[0]), .mem_wdata_o(wdata[0]), .cpu_rst_n_o(rstn[0]),
      .done_o(done[0]), .err_o(err[0]), .byte_cnt_o(cnt[0])
   );

   imem_boot_loader #(.ADDR_W(10), .BASE_ADDR('h3FE)) dut1 (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .in_valid_i(in_valid_i),
      .in_data_i(in_data_i), .in_ready_o(rdy[1]), .mem_we_o(we[1]),
      .mem_addr_o(addr[1]), .mem_wdata_o(wdata[1]), .cpu_rst_n_o(rstn[1]),
      .done_o(done[1]), .err_o(err[1]), .byte_cnt_o(cnt[1])
   );

   // Frame-level model: counts bytes consumed in the frame and decides the outcome from LEN and the XOR.
   bit         model_on = 1'b0;
   int         m_active [2];
   int         m_fresh [2];
   int         m_got [2];
   int         m_len [2];
   int         m_cnt [2];
   int         m_outcome [2];
   int         m_we [2];
   int         m_addr [2];
   int         m_wdata [2];
   logic [7:0] m_acc [2];

   function automatic int mbase(input int i);
      return (i == 0) ? 0 : 'h3FE;
   endfunction

   function automatic int m_ready(input int i);
      return (m_active[i] != 0 && m_fresh[i] == 0 && m_outcome[i] == 0) ? 1 : 0;
   endfunction

   always @(posedge clk) begin
      int mr;
      for (int i = 0; i < 2; i++) begin
         mr = m_ready(i);
         if (rst_i) begin
            model_on     = 1'b1;
            m_active[i]  = 0;
            m_fresh[i]   = 0;
            m_got[i]     = 0;
            m_len[i]     = 0;
            m_cnt[i]     = 0;
            m_outcome[i] = 0;
            m_we[i]      = 0;
            m_addr[i]    = 0;
            m_wdata[i]   = 0;
            m_acc[i]     = 8'h00;
         end else begin
            m_we[i] = 0;
            if (start_i) begin
               m_active[i]  = 1;
               m_fresh[i]   = 1;
               m_got[i]     = 0;
               m_len[i]     = 0;
               m_cnt[i]     = 0;
               m_outcome[i] = 0;
               m_acc[i]     = 8'h00;
            end else begin
               m_fresh[i] = 0;
               if (in_valid_i && mr != 0) begin
                  if (m_got[i] == 0) begin
                     m_len[i] = int'(in_data_i);
                  end else if (m_got[i] == 1) begin
                     m_len[i] = m_len[i] + int'(in_data_i) * 256;
                     if (m_len[i] > 1024 - mbase(i)) m_outcome[i] = 2;
                  end else if (m_got[i] < m_len[i] + 2) begin
                     m_we[i]    = 1;
                     m_addr[i]  = (mbase(i) + m_cnt[i]) % 1024;
                     m_wdata[i] = int'(in_data_i);
                     m_acc[i]   = m_acc[i] ^ in_data_i;
                     m_cnt[i]   = m_cnt[i] + 1;
                  end else begin
                     m_outcome[i] = (in_data_i == m_acc[i]) ? 1 : 2;
                  end
                  m_got[i] = m_got[i] + 1;
               end
            end
         end
      end
   end

   int cyc = 0;
   int logn [2];
   int logcyc  [2][64];
   int logaddr [2][64];
   int logdata [2][64];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   // Runs mid-cycle: compares both instances to the model and logs every write seen.
   task automatic compareModel();
      cyc++;
      for (int i = 0; i < 2; i++) begin
         if (model_on) begin
            checkOutput($sformatf("ready%0d", i), {31'd0, rdy[i]}, m_ready(i));
            checkOutput($sformatf("we%0d", i), {31'd0, we[i]}, m_we[i]);
            checkOutput($sformatf("done%0d", i), {31'd0, done[i]}, (m_outcome[i] == 1) ? 1 : 0);
            checkOutput($sformatf("err%0d", i), {31'd0, err[i]}, (m_outcome[i] == 2) ? 1 : 0);
            checkOutput($sformatf("cpu_rst_n%0d", i), {31'd0, rstn[i]}, (m_outcome[i] == 1) ? 1 : 0);
            checkOutput($sformatf("byte_cnt%0d", i), {16'd0, cnt[i]}, m_cnt[i]);
            if (m_we[i] != 0) begin
               checkOutput($sformatf("addr%0d", i), {22'd0, addr[i]}, m_addr[i]);
               checkOutput($sformatf("wdata%0d", i), {24'd0, wdata[i]}, m_wdata[i]);
            end
            if (we[i] === 1'b1 && logn[i] < 64) begin
               logcyc[i][logn[i]]  = cyc;
               logaddr[i][logn[i]] = int'(addr[i]);
               logdata[i][logn[i]] = int'(wdata[i]);
               logn[i]++;
            end
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      compareModel();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic rst, input logic start, input logic valid, input logic [7:0] data);
      rst_i      = rst;
      start_i    = start;
      in_valid_i = valid;
      in_data_i  = data;
      tick();
   endtask

   task automatic sendByte(input logic [7:0] b);
      logic was_ready;
      rst_i      = 1'b0;
      start_i    = 1'b0;
      in_valid_i = 1'b1;
      in_data_i  = b;
      was_ready  = 1'b0;
      for (int k = 0; k < 32; k++) begin
         was_ready = rdy[0];
         tick();
         if (was_ready) break;
      end
      if (!was_ready) checkOutput("send_timeout", {31'd0, was_ready}, 1);
   endtask

   task automatic clearLogs();
      logn[0] = 0;
      logn[1] = 0;
   endtask

   task automatic checkWrite(input string name, input int i, input int idx, input int a, input int d);
      checkOutput({name, "_addr"}, logaddr[i][idx], a);
      checkOutput({name, "_data"}, logdata[i][idx], d);
   endtask

   task automatic checkResetOutputs(input int i);
      checkOutput($sformatf("rst_ready%0d", i), {31'd0, rdy[i]}, 0);
      checkOutput($sformatf("rst_we%0d", i), {31'd0, we[i]}, 0);
      checkOutput($sformatf("rst_addr%0d", i), {22'd0, addr[i]}, 0);
      checkOutput($sformatf("rst_wdata%0d", i), {24'd0, wdata[i]}, 0);
      checkOutput($sformatf("rst_cpu_rst_n%0d", i), {31'd0, rstn[i]}, 0);
      checkOutput($sformatf("rst_done%0d", i), {31'd0, done[i]}, 0);
      checkOutput($sformatf("rst_err%0d", i), {31'd0, err[i]}, 0);
      checkOutput($sformatf("rst_byte_cnt%0d", i), {16'd0, cnt[i]}, 0);
   endtask

   initial begin
      logic [7:0] payload [5];
      int         gaps [5];
      payload = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10};
      gaps    = '{0, 2, 1, 3, 0};
      clearLogs();

      applyStimulus(1, 0, 0, 8'h00);
      applyStimulus(1, 0, 0, 8'h00);
      checkResetOutputs(0);
      checkResetOutputs(1);

      // Clean load; the base-0x3FE instance rejects LEN=3 as oversize.
      clearLogs();
      applyStimulus(0, 1, 0, 8'h00);
      checkOutput("ready_after_start", {31'd0, rdy[0]}, 0);
      sendByte(8'h03); sendByte(8'h00);
      sendByte(8'h30); sendByte(8'hF0); sendByte(8'h11);
      sendByte(8'hD1);
      checkOutput("clean_done", {31'd0, done[0]}, 1);
      checkOutput("clean_cpu_rst_n", {31'd0, rstn[0]}, 1);
      checkOutput("clean_byte_cnt", {16'd0, cnt[0]}, 3);
      checkOutput("oversize_err", {31'd0, err[1]}, 1);
      checkOutput("oversize_cpu_rst_n", {31'd0, rstn[1]}, 0);
      applyStimulus(0, 0, 0, 8'h00);
      checkOutput("clean_nwrites", logn[0], 3);
      checkWrite("clean_w0", 0, 0, 0, 'h30);
      checkWrite("clean_w1", 0, 1, 1, 'hF0);
      checkWrite("clean_w2", 0, 2, 2, 'h11);
      checkOutput("clean_b2b_01", logcyc[0][1] - logcyc[0][0], 1);
      checkOutput("clean_b2b_12", logcyc[0][2] - logcyc[0][1], 1);
      checkOutput("oversize_nwrites", logn[1], 0);
      checkOutput("oversize_ready", {31'd0, rdy[1]}, 0);

      // Bad checksum.
      clearLogs();
      applyStimulus(0, 1, 0, 8'h00);
      sendByte(8'h03); sendByte(8'h00);
      sendByte(8'h30); sendByte(8'hF0); sendByte(8'h11);
      sendByte(8'hD0);
      checkOutput("badcs_err", {31'd0, err[0]}, 1);
      checkOutput("badcs_cpu_rst_n", {31'd0, rstn[0]}, 0);
      checkOutput("badcs_done", {31'd0, done[0]}, 0);
      applyStimulus(0, 0, 0, 8'h00);
      checkOutput("badcs_nwrites", logn[0], 3);

      // Zero length, then restart from DONE.
      clearLogs();
      applyStimulus(0, 1, 0, 8'h00);
      sendByte(8'h00); sendByte(8'h00); sendByte(8'h00);
      checkOutput("zero_done", {31'd0, done[0]}, 1);
      checkOutput("zero_done_hi", {31'd0, done[1]}, 1);
      applyStimulus(0, 0, 0, 8'h00);
      checkOutput("zero_nwrites", logn[0], 0);
      applyStimulus(0, 1, 0, 8'h00);
      checkOutput("restart_done", {31'd0, done[0]}, 0);
      checkOutput("restart_cpu_rst_n", {31'd0, rstn[0]}, 0);

      // LEN=2 fills the last two bytes of memory on the high-base instance.
      sendByte(8'h02); sendByte(8'h00);
      sendByte(8'hAA); sendByte(8'h55);
      sendByte(8'hFF);
      checkOutput("len2_done_hi", {31'd0, done[1]}, 1);
      checkOutput("len2_done_lo", {31'd0, done[0]}, 1);
      applyStimulus(0, 0, 0, 8'h00);
      checkOutput("len2_nwrites_hi", logn[1], 2);
      checkWrite("len2_hi_w0", 1, 0, 'h3FE, 'hAA);
      checkWrite("len2_hi_w1", 1, 1, 'h3FF, 'h55);

      // Backpressure gaps during DATA.
      clearLogs();
      applyStimulus(0, 1, 0, 8'h00);
      sendByte(8'h05); sendByte(8'h00);
      for (int k = 0; k < 5; k++) begin
         for (int g = 0; g < gaps[k]; g++) applyStimulus(0, 0, 0, 8'hEE);
         sendByte(payload[k]);
      end
      sendByte(8'h1F);
      checkOutput("bp_done", {31'd0, done[0]}, 1);
      checkOutput("bp_byte_cnt", {16'd0, cnt[0]}, 5);
      applyStimulus(0, 0, 0, 8'h00);
      checkOutput("bp_nwrites", logn[0], 5);
      for (int k = 0; k < 5; k++) checkWrite($sformatf("bp_w%0d", k), 0, k, k, int'(payload[k]));

      // Reset after the second payload byte.
      clearLogs();
      applyStimulus(0, 1, 0, 8'h00);
      sendByte(8'h04); sendByte(8'h00);
      sendByte(8'hA1); sendByte(8'hB2);
      applyStimulus(1, 0, 1, 8'hC3);
      checkResetOutputs(0);
      checkResetOutputs(1);
      for (int k = 0; k < 3; k++) applyStimulus(0, 0, 1, 8'hC3);
      checkOutput("rst_nwrites", logn[0], 2);
      checkOutput("rst_idle_ready", {31'd0, rdy[0]}, 0);

      // Abort during DATA, then a fresh frame loads from the base.
      applyStimulus(0, 1, 0, 8'h00);
      sendByte(8'h04); sendByte(8'h00);
      sendByte(8'h11); sendByte(8'h22);
      applyStimulus(0, 1, 1, 8'h33);
      checkOutput("abort_ready", {31'd0, rdy[0]}, 0);
      checkOutput("abort_byte_cnt", {16'd0, cnt[0]}, 0);
      clearLogs();
      sendByte(8'h01); sendByte(8'h00);
      sendByte(8'h77); sendByte(8'h77);
      checkOutput("abort_done", {31'd0, done[0]}, 1);
      applyStimulus(0, 0, 0, 8'h00);
      checkOutput("abort_nwrites", logn[0], 1);
      checkWrite("abort_w0", 0, 0, 0, 'h77);
      checkOutput("abort_nwrites_hi", logn[1], 1);
      checkWrite("abort_hi_w0", 1, 0, 'h3FE, 'h77);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

endmodule
